// File: rtl/txshift_pkg.sv
// Shared types and constants for the txshift UART transmit engine.
// Contents: frame state encoding, data/baud widths and the line levels used
// for each part of an 8N1 frame.
package txshift_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  localparam int DATA_BITS = 8;
  localparam int BAUD_W    = 8;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/txshift_baud_tick.sv
// Bit-period timer for txshift.
// Latches the bit period on 'clear' (frame start) and counts 0..P-1 while
// 'run' is high, raising 'tick' on the last cycle of each bit period.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset (clears the counter)
//   clear - frame start: load period from 'baud', zero the counter
//   run   - count enable (a frame is in progress)
//   baud  - requested period in clk cycles (0 is treated as 1)
//   tick  - high on the final cycle of the current bit period
module txshift_baud_tick
  import txshift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [BAUD_W-1:0] baud,
  output logic              tick
);

  logic [BAUD_W-1:0] period;
  logic [BAUD_W-1:0] count;

  // A zero period would never produce a tick; clamp it to one cycle per bit.
  function automatic logic [BAUD_W-1:0] sat_period(input logic [BAUD_W-1:0] b);
    return (b == '0) ? BAUD_W'(1) : b;
  endfunction

  // Period is configuration data, loaded only at frame start.
  always_ff @(posedge clk) begin
    if (clear) period <= sat_period(baud);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (tick) count <= '0;
      else      count <= count + BAUD_W'(1);
    end
  end

  assign tick = (count == period - BAUD_W'(1));

endmodule

// File: rtl/txshift.sv
// UART 8N1 transmit shift engine.
// Sends one byte as start bit, 8 data bits LSB first, stop bit; each bit is
// held for a run-time number of clock cycles taken from i_Baud at frame start.
// Ports:
//   i_Pclk      - peripheral clock, all logic on rising edge
//   i_Reset     - synchronous active-high reset
//   i_Baud      - bit period in i_Pclk cycles (0 behaves as 1)
//   i_Enable    - transmit request, sampled only while idle
//   i_Data      - byte to send, latched at frame start
//   o_Tx_Serial - serial line, idle high (registered)
//   o_Pready    - one-cycle pulse when a frame completes (registered)
module txshift
  import txshift_pkg::*;
(
  input  logic              i_Pclk,
  input  logic              i_Reset,
  input  logic [BAUD_W-1:0] i_Baud,
  input  logic              i_Enable,
  input  logic [7:0]        i_Data,
  output logic              o_Tx_Serial,
  output logic              o_Pready
);

  state_t         state_q;
  state_t         state_d;
  logic           load;
  logic           tick;
  logic           line_d;
  logic [2:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  txshift_baud_tick u_baud_tick (
    .clk   (i_Pclk),
    .rst   (i_Reset),
    .clear (load),
    .run   (state_q != IDLE),
    .baud  (i_Baud),
    .tick  (tick)
  );

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_Enable) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: if (tick) state_d = DATA;
      DATA:  if (tick && bit_idx == 3'(DATA_BITS - 1)) state_d = STOP;
      STOP:  if (tick) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line level for the current state; registering it below keeps the line
  // glitch-free and delays it one cycle behind the state register.
  always_comb begin
    line_d = IDLE_LVL;
    case (state_q)
      START: line_d = START_LVL;
      DATA:  line_d = shift_reg[bit_idx];
      STOP:  line_d = STOP_LVL;
      default: line_d = IDLE_LVL;
    endcase
  end

  // Latched byte is data only; it is rewritten at every frame start.
  always_ff @(posedge i_Pclk) begin
    if (load) shift_reg <= i_Data;
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      bit_idx     <= '0;
      o_Tx_Serial <= IDLE_LVL;
      o_Pready    <= 1'b0;
    end else begin
      o_Tx_Serial <= line_d;
      o_Pready    <= (state_q == DONE);
      if (state_q != DATA)  bit_idx <= '0;
      else if (tick)        bit_idx <= bit_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_txshift.sv
module tb_txshift;

  logic       i_Pclk = 1'b0;
  logic       i_Reset;
  logic [7:0] i_Baud;
  logic       i_Enable;
  logic [7:0] i_Data;
  logic       o_Tx_Serial;
  logic       o_Pready;

  txshift dut (
    .i_Pclk      (i_Pclk),
    .i_Reset     (i_Reset),
    .i_Baud      (i_Baud),
    .i_Enable    (i_Enable),
    .i_Data      (i_Data),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Pready    (o_Pready)
  );

  always #5 i_Pclk = ~i_Pclk;

  typedef struct {
    logic [7:0] data;
    int         p;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic [7:0] b);
    frame_t f;
    f.data = d;
    f.p    = (b == 8'd0) ? 1 : int'(b);
    exp_q.push_back(f);
  endtask

  task automatic drive(input logic [7:0] d, input logic [7:0] b);
    @(negedge i_Pclk);
    i_Data   = d;
    i_Baud   = b;
    i_Enable = 1'b1;
    push_frame(d, b);
  endtask

  // Pops one expected frame and checks it on the line, sampling each negedge.
  task automatic check_frame(input string name, input int exp_lat, input bit keep_en);
    frame_t f;
    int     lat;
    bit     got_fall;
    int     obs;
    int     pr_hi;
    if (exp_q.size() == 0) begin
      check_eq({name, "_queue"}, 0, 1);
      return;
    end
    f = exp_q.pop_front();
    lat = 0;
    got_fall = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge i_Pclk);
      if (o_Tx_Serial === 1'b0) begin
        got_fall = 1'b1;
        break;
      end
      lat++;
    end
    check_eq({name, "_fall"}, int'(got_fall), 1);
    if (!got_fall) return;
    check_eq({name, "_lat"}, lat, exp_lat);
    pr_hi = 0;
    for (int s = 0; s < 10; s++) begin
      int e;
      e = (s == 0) ? 0 : (s == 9) ? 1 : int'(f.data[s-1]);
      obs = e;
      for (int c = 0; c < f.p; c++) begin
        if (!(s == 0 && c == 0)) @(negedge i_Pclk);
        if (o_Tx_Serial !== e[0]) obs = int'(o_Tx_Serial);
        if (o_Pready !== 1'b0) pr_hi++;
      end
      check_eq($sformatf("%s_seg%0d", name, s), obs, e);
    end
    check_eq({name, "_pready_mid"}, pr_hi, 0);
    @(negedge i_Pclk);
    check_eq({name, "_pready_hi"}, int'(o_Pready), 1);
    check_eq({name, "_line_done"}, int'(o_Tx_Serial), 1);
    if (!keep_en) i_Enable = 1'b0;
    @(negedge i_Pclk);
    check_eq({name, "_pready_lo"}, int'(o_Pready), 0);
    check_eq({name, "_line_idle"}, int'(o_Tx_Serial), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_line;
    int bad_rdy;

    i_Reset  = 1'b1;
    i_Enable = 1'b0;
    i_Baud   = 8'd87;
    i_Data   = 8'h00;
    repeat (3) @(negedge i_Pclk);
    check_eq("rst_line", int'(o_Tx_Serial), 1);
    check_eq("rst_pready", int'(o_Pready), 0);
    i_Reset = 1'b0;

    // Idle with enable low
    bad_line = 0;
    bad_rdy  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge i_Pclk);
      if (o_Tx_Serial !== 1'b1) bad_line++;
      if (o_Pready !== 1'b0) bad_rdy++;
    end
    check_eq("idle_line", bad_line, 0);
    check_eq("idle_pready", bad_rdy, 0);

    // Single 0x53 frame at P=87, enable held until completion
    drive(8'h53, 8'd87);
    check_frame("f53", 1, 1'b0);

    // Back-to-back 0xA5 frames at P=4
    drive(8'hA5, 8'd4);
    push_frame(8'hA5, 8'd4);
    check_frame("bb1", 1, 1'b1);
    check_frame("bb2", 0, 1'b0);
    bad_line = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_Pclk);
      if (o_Tx_Serial !== 1'b1) bad_line++;
    end
    check_eq("bb_after_idle", bad_line, 0);

    // Inputs changed mid-frame are ignored
    drive(8'hFF, 8'd10);
    fork
      check_frame("hold", 1, 1'b0);
      begin
        repeat (35) @(negedge i_Pclk);
        i_Enable = 1'b0;
        i_Data   = 8'h00;
        i_Baud   = 8'd3;
      end
    join

    // Reset during data bit 3 of a 0xF0 frame at P=4
    drive(8'hF0, 8'd4);
    @(negedge i_Pclk);
    i_Enable = 1'b0;
    repeat (17) @(negedge i_Pclk);
    check_eq("abort_bit3", int'(o_Tx_Serial), 0);
    i_Reset = 1'b1;
    @(negedge i_Pclk);
    check_eq("abort_line", int'(o_Tx_Serial), 1);
    check_eq("abort_pready", int'(o_Pready), 0);
    exp_q.delete();
    @(negedge i_Pclk);
    i_Reset = 1'b0;
    check_eq("abort_line2", int'(o_Tx_Serial), 1);
    drive(8'h5A, 8'd2);
    check_frame("post_rst", 1, 1'b0);

    // Minimum period, both explicit 1 and zero
    drive(8'h01, 8'd1);
    check_frame("b1", 1, 1'b0);
    drive(8'h01, 8'd0);
    check_frame("b0", 1, 1'b0);

    check_eq("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
